osci_axil_regs: RTL

AXI4-Lite slave (responder) that terminates the CPU-side register interface of the oscilloscope IP.
- Provides four plain RW control registers, a read-only status register and a pop-on-read sample window.
- The window drains an internal FIFO filled by the acquisition path.
- Sits between the AXI interconnect / VIP master and the oscilloscope capture logic.

---
 rtl/osci_axil_pkg.sv | 28 ++
 rtl/osci_sample_fifo.sv | 58 +++++
 rtl/osci_axil_regs.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/osci_axil_pkg.sv
// Shared constants and types for the oscilloscope AXI4-Lite register block.
// Latency: n/a (package only).
// Backpressure: n/a.
package osci_axil_pkg;

  // Byte offsets of the register map; decode uses bits [4:2] only.
  localparam logic [4:0] OFS_CTRL0  = 5'h00;
  localparam logic [4:0] OFS_CTRL1  = 5'h04;
  localparam logic [4:0] OFS_CTRL2  = 5'h08;
  localparam logic [4:0] OFS_CTRL3  = 5'h0C;
  localparam logic [4:0] OFS_STATUS = 5'h10;
  localparam logic [4:0] OFS_SAMPLE = 5'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // STATUS / SAMPLE word bit positions.
  localparam int STAT_FULL_BIT  = 16;
  localparam int STAT_EMPTY_BIT = 17;
  localparam int STAT_OVF_BIT   = 31;
  localparam int SMP_VALID_BIT  = 31;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

endpackage

// File: rtl/osci_sample_fifo.sv
// Synchronous sample FIFO with push/pop, occupancy level and full/empty flags.
// Latency: a pushed sample is visible at the head the cycle after the push.
// Backpressure: none; push while full and pop while empty are ignored.
module osci_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  // Flags come from the level before this cycle's push/pop.
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and level bookkeeping; push+pop together leaves the level unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sample storage; contents need no reset because the level guards them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/osci_axil_regs.sv
// AXI4-Lite responder: 4 RW ctrl regs, RO STATUS, pop-on-read SAMPLE window over a FIFO.
// Latency: write response 2 cycles after both AW and W are taken; read data 1 cycle after AR.
// Backpressure: one write and one read outstanding; optional irq output under OSCI_AXIL_IRQ_EN.
module osci_axil_regs
  import osci_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_WIDTH       = 16,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            smp_valid,
  input  logic [SAMPLE_WIDTH-1:0]         smp_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg3
`ifdef OSCI_AXIL_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  wstate_e             wstate_q;
  logic                aw_lat_q, w_lat_q, bvalid_q;
  logic [2:0]          awaddr_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     wstrb_q;
  logic [1:0]          bresp_q, bresp_d;
  logic [DW-1:0]       ctrl_q [4];
  logic [DW-1:0]       ctrl_d [4];
  logic                rvalid_q, ovf_q;
  logic [DW-1:0]       rdata_q, rdata_d, status_word, sample_word;
  logic [1:0]          rresp_q, rresp_d;
  logic                aw_hs, w_hs, ar_hs, wr_apply, fifo_pop, stat_rd, ovf_set;
  logic [SAMPLE_WIDTH-1:0] fifo_head;
  logic [LVL_W-1:0]    fifo_level;
  logic                fifo_full, fifo_empty;
  logic                unused_sigs;

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are forced low while reset is held so nothing is accepted mid-reset.
  assign S_AXI_AWREADY = !ARESET && (wstate_q == W_IDLE) && !aw_lat_q;
  assign S_AXI_WREADY  = !ARESET && (wstate_q == W_IDLE) && !w_lat_q;
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_reg0 = ctrl_q[0];
  assign ctrl_reg1 = ctrl_q[1];
  assign ctrl_reg2 = ctrl_q[2];
  assign ctrl_reg3 = ctrl_q[3];

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_apply = (wstate_q == W_IDLE) && aw_lat_q && w_lat_q;
  assign ovf_set  = smp_valid && fifo_full;

  osci_sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (smp_valid),
    .pop_i   (fifo_pop),
    .data_i  (smp_data),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Byte-merge the latched write into the ctrl regs and pick the write response.
  always_comb begin
    ctrl_d  = ctrl_q;
    bresp_d = RESP_SLVERR;
    if (wr_apply) begin
      case (awaddr_q)
        OFS_CTRL0[4:2], OFS_CTRL1[4:2], OFS_CTRL2[4:2], OFS_CTRL3[4:2]: begin
          bresp_d = RESP_OKAY;
          for (int b = 0; b < DW / 8; b++) begin
            if (wstrb_q[b]) ctrl_d[awaddr_q[1:0]][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
        default: bresp_d = RESP_SLVERR;
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, apply, then hold B until taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_lat_q <= 1'b1;
            awaddr_q <= S_AXI_AWADDR[4:2];
          end
          if (w_hs) begin
            w_lat_q <= 1'b1;
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (wr_apply) begin
            aw_lat_q <= 1'b0;
            w_lat_q  <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= bresp_d;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Control register storage.
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < 4; i++) ctrl_q[i] <= ARESET ? '0 : ctrl_d[i];
  end

  // STATUS and SAMPLE word assembly.
  always_comb begin
    status_word = '0;
    status_word[LVL_W-1:0]      = fifo_level;
    status_word[STAT_FULL_BIT]  = fifo_full;
    status_word[STAT_EMPTY_BIT] = fifo_empty;
    status_word[STAT_OVF_BIT]   = ovf_q;
    sample_word = '0;
    sample_word[SAMPLE_WIDTH-1:0] = fifo_head;
    sample_word[SMP_VALID_BIT]    = 1'b1;
  end

  // Read decode; side effects (pop, overflow clear) only fire on the AR handshake.
  always_comb begin
    rdata_d  = '0;
    rresp_d  = RESP_OKAY;
    fifo_pop = 1'b0;
    stat_rd  = 1'b0;
    case (S_AXI_ARADDR[4:2])
      OFS_CTRL0[4:2]:  rdata_d = ctrl_q[0];
      OFS_CTRL1[4:2]:  rdata_d = ctrl_q[1];
      OFS_CTRL2[4:2]:  rdata_d = ctrl_q[2];
      OFS_CTRL3[4:2]:  rdata_d = ctrl_q[3];
      OFS_STATUS[4:2]: begin
        rdata_d = status_word;
        stat_rd = ar_hs;
      end
      OFS_SAMPLE[4:2]: begin
        if (!fifo_empty) begin
          rdata_d  = sample_word;
          fifo_pop = ar_hs;
        end
      end
      default: rresp_d = RESP_SLVERR;
    endcase
  end

  // Read channel: register data on AR, hold until R is taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  // Sticky overflow: a new drop beats a clearing STATUS read in the same cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET)       ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (stat_rd) ovf_q <= 1'b0;
  end

`ifdef OSCI_AXIL_IRQ_EN
  // Level-threshold interrupt, gated by ctrl_reg0[0]; threshold 0 disables it.
  always_ff @(posedge ACLK) begin
    if (ARESET) irq <= 1'b0;
    else irq <= ctrl_q[0][0] && (status_word[15:0] >= {8'd0, ctrl_q[3][7:0]})
                && (ctrl_q[3][7:0] != 8'd0);
  end
`endif

endmodule
